// File: rtl/rotating_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rotating_led_ctrl
// Purpose  : Advances a square around a loop on a 4-digit seven-segment
//            display, paced by a divided tick, with direction, pause and
//            single-step controls.
// Revision : 1.0 - initial release
// ============================================================================
module rotating_led_ctrl #(
    parameter int SPEED_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_i,
    input  logic               en_i,
    input  logic               cw_i,
    input  logic [SPEED_W-1:0] speed_i,
    input  logic               step_i,
    output logic [2:0]         pos_o,
    output logic [3:0]         an_o,
    output logic [7:0]         sseg_o,
    output logic               step_pulse_o
);

    localparam logic [7:0] C_SSEG_UPPER = 8'h9C;
    localparam logic [7:0] C_SSEG_LOWER = 8'hA3;

    logic [2:0]         pos_q, pos_d;
    logic [SPEED_W-1:0] div_cnt_q, div_cnt_d;
    logic               step_pulse_q, step_pulse_d;
    logic               w_advance;
    logic [1:0]         w_digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q        <= 3'd0;
            div_cnt_q    <= '0;
            step_pulse_q <= 1'b0;
        end else begin
            pos_q        <= pos_d;
            div_cnt_q    <= div_cnt_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    // en selects the advance source, so tick and step can never both act.
    always_comb begin
        pos_d     = pos_q;
        div_cnt_d = div_cnt_q;
        w_advance = 1'b0;
        if (en_i) begin
            if (tick_i) begin
                if (div_cnt_q >= speed_i) begin
                    div_cnt_d = '0;
                    w_advance = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + SPEED_W'(1);
                end
            end
        end else if (step_i) begin
            w_advance = 1'b1;
        end
        if (w_advance) begin
            pos_d = cw_i ? pos_q + 3'd1 : pos_q - 3'd1;
        end
        step_pulse_d = w_advance;
    end

    // Lower half of the loop runs right-to-left: digit = 7 - pos = ~pos[1:0].
    assign w_digit      = pos_q[2] ? ~pos_q[1:0] : pos_q[1:0];
    assign an_o         = ~(4'b0001 << w_digit);
    assign sseg_o       = pos_q[2] ? C_SSEG_LOWER : C_SSEG_UPPER;
    assign pos_o        = pos_q;
    assign step_pulse_o = step_pulse_q;

endmodule
`default_nettype wire
